// File: rtl/cmos_cap_pkg.sv
// rtl/cmos_cap_pkg.sv - shared types and constants for the CMOS capture/pack block
// Contents: capture state encoding, default address-load pulse width,
//           RGB565-to-gray luma coefficients and shift.
package cmos_cap_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_t;

  localparam int unsigned LOAD_CYCLES_DEF = 4;

  localparam logic [15:0] GRAY_COEF_R = 16'd77;
  localparam logic [15:0] GRAY_COEF_G = 16'd150;
  localparam logic [15:0] GRAY_COEF_B = 16'd29;
  localparam int unsigned GRAY_SHIFT  = 8;

endpackage

// File: rtl/rgb565_to_gray.sv
// rtl/rgb565_to_gray.sv - one-stage registered RGB565 to gray RGB565 converter
// Ports: i_clk, i_rst (async, active-high)
//        i_valid/i_data  : input strobe and RGB565 word
//        o_valid/o_data  : strobe and gray word, one cycle later; o_data holds between strobes
module rgb565_to_gray
  import cmos_cap_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  output logic        o_valid,
  output logic [15:0] o_data
);

  logic [7:0]  w_r8, w_g8, w_b8;
  logic [15:0] w_sum;
  logic [7:0]  w_y;
  logic        w_unused_frac;

  // MSB replication widens each channel to a full 0..255 range.
  assign w_r8 = {i_data[15:11], i_data[15:13]};
  assign w_g8 = {i_data[10:5],  i_data[10:9]};
  assign w_b8 = {i_data[4:0],   i_data[4:2]};

  // Coefficients sum to 256, so the 16-bit accumulator cannot overflow.
  assign w_sum = GRAY_COEF_R * {8'd0, w_r8}
               + GRAY_COEF_G * {8'd0, w_g8}
               + GRAY_COEF_B * {8'd0, w_b8};
  assign w_y           = w_sum[GRAY_SHIFT +: 8];
  assign w_unused_frac = ^w_sum[GRAY_SHIFT-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= 16'd0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data <= {w_y[7:3], w_y[7:2], w_y[7:3]};
      end
    end
  end

endmodule

// File: rtl/cmos_capture_pack.sv
// rtl/cmos_capture_pack.sv - OV5640 DVP capture, RGB565 packing and frame-start load pulse
// Ports: clk_write (PCLK), rst (async, active-high)
//        cmos_vsync, cmos_href, cmos_data[7:0] : camera DVP bus
//        wrf_wrreq, wrf_din[15:0]              : SDRAM write-FIFO strobe and word
//        wr_load                               : stretched frame-start address reload
//        frame_valid, frame_cnt[15:0]          : capture-in-progress flag, captured frame count
//        line_err                              : sticky odd-byte-count line flag
// Optional: define CMOS_GRAY_CONV_EN to convert each word to gray (adds one cycle of latency).
module cmos_capture_pack
  import cmos_cap_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES    = 10,
  parameter int unsigned LOAD_CYCLES    = LOAD_CYCLES_DEF,
  parameter int unsigned VS_ACTIVE_HIGH = 1
) (
  input  logic        clk_write,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        wrf_wrreq,
  output logic [15:0] wrf_din,
  output logic        wr_load,
  output logic        frame_valid,
  output logic [15:0] frame_cnt,
  output logic        line_err
);

  localparam logic [15:0] SKIP_W = 16'(SKIP_FRAMES);
  localparam logic [7:0]  LOAD_W = 8'(LOAD_CYCLES);

  logic        r_vs, r_vs_rr, r_hr, r_hr_d;
  logic [7:0]  r_d, r_hi;
  logic        r_phase;
  cap_state_t  r_state, w_state_nxt;
  logic [15:0] r_skip_cnt, r_frame_cnt, r_din;
  logic [7:0]  r_load_cnt;
  logic        r_frame_valid, r_line_err, r_wrreq;
  logic        w_vs_rise, w_vs_fall;

  // Input register stage; vs is normalised so 1 always means "in sync pulse".
  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_vs    <= 1'b0;
      r_vs_rr <= 1'b0;
      r_hr    <= 1'b0;
      r_hr_d  <= 1'b0;
      r_d     <= 8'd0;
    end else begin
      r_vs    <= (VS_ACTIVE_HIGH != 0) ? cmos_vsync : ~cmos_vsync;
      r_vs_rr <= r_vs;
      r_hr    <= cmos_href;
      r_hr_d  <= r_hr;
      r_d     <= cmos_data;
    end
  end

  assign w_vs_rise = r_vs & ~r_vs_rr;
  assign w_vs_fall = ~r_vs & r_vs_rr;

  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) r_state <= ST_SETTLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SETTLE: if (w_vs_rise && (r_skip_cnt == SKIP_W)) w_state_nxt = ST_SYNC;
      ST_SYNC:   if (w_vs_fall) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (w_vs_rise) w_state_nxt = ST_SYNC;
      default:   w_state_nxt = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_write or posedge rst) begin
    if (rst) begin
      r_skip_cnt    <= 16'd0;
      r_load_cnt    <= 8'd0;
      r_frame_valid <= 1'b0;
      r_frame_cnt   <= 16'd0;
      r_line_err    <= 1'b0;
      r_phase       <= 1'b0;
      r_hi          <= 8'd0;
      r_wrreq       <= 1'b0;
      r_din         <= 16'd0;
    end else begin
      r_wrreq <= 1'b0;

      if (r_state == ST_SETTLE && w_vs_rise && (r_skip_cnt != SKIP_W)) begin
        r_skip_cnt <= r_skip_cnt + 16'd1;
      end

      // The load counter runs on its own so later vs edges cannot cut the pulse short.
      if (r_load_cnt != 8'd0) begin
        r_load_cnt <= r_load_cnt - 8'd1;
      end
      if (r_state == ST_SYNC && w_vs_fall) begin
        r_load_cnt    <= LOAD_W;
        r_frame_valid <= 1'b1;
      end

      if (r_state == ST_ACTIVE) begin
        if (w_vs_rise) begin
          // Frame end wins over any byte in this cycle; a half word is dropped.
          r_frame_valid <= 1'b0;
          r_frame_cnt   <= r_frame_cnt + 16'd1;
          r_phase       <= 1'b0;
        end else if (r_hr) begin
          if (!r_phase) begin
            r_hi    <= r_d;
            r_phase <= 1'b1;
          end else begin
            r_din   <= {r_hi, r_d};
            r_wrreq <= 1'b1;
            r_phase <= 1'b0;
          end
        end else if (r_hr_d) begin
          if (r_phase) r_line_err <= 1'b1;
          r_phase <= 1'b0;
        end
      end else begin
        r_phase <= 1'b0;
      end
    end
  end

  assign wr_load     = (r_load_cnt != 8'd0);
  assign frame_valid = r_frame_valid;
  assign frame_cnt   = r_frame_cnt;
  assign line_err    = r_line_err;

`ifdef CMOS_GRAY_CONV_EN
  logic        w_gray_valid;
  logic [15:0] w_gray_data;

  rgb565_to_gray u_gray (
    .i_clk   (clk_write),
    .i_rst   (rst),
    .i_valid (r_wrreq),
    .i_data  (r_din),
    .o_valid (w_gray_valid),
    .o_data  (w_gray_data)
  );

  assign wrf_wrreq = w_gray_valid;
  assign wrf_din   = w_gray_data;
`else
  assign wrf_wrreq = r_wrreq;
  assign wrf_din   = r_din;
`endif

endmodule
